// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - iterative multi-cycle shifter/rotator with start/busy/done handshake
//
// Purpose: shifts or rotates a captured operand by a variable amount, at most
// STEP bits per clock, and loads the result into a held output register.
//
// Ports:
//   clk     in   1        rising-edge clock
//   rst_n   in   1        asynchronous active-low reset
//   start   in   1        request; accepted in IDLE or DONE only
//   ctrl    in   3        mode: 010 SLL, 001 SRA, 011 SRL, 100 ROL, 101 ROR, else PASS
//   amount  in   SH_BITS  shift distance 0 .. NBITS-1
//   y       in   NBITS    operand
//   busy    out  1        high while in SHIFT
//   done    out  1        one-cycle completion pulse
//   c       out  NBITS    result register, held until the next completion

module seq_shifter #(
    parameter int NBITS   = 32,
    parameter int SH_BITS = $clog2(NBITS),
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         ctrl,
    input  logic [SH_BITS-1:0] amount,
    input  logic [NBITS-1:0]   y,
    output logic               busy,
    output logic               done,
    output logic [NBITS-1:0]   c
);

    localparam logic [2:0] MODE_SLL = 3'b010;
    localparam logic [2:0] MODE_SRA = 3'b001;
    localparam logic [2:0] MODE_SRL = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;
    localparam logic [2:0] MODE_ROR = 3'b101;

    // One extra bit so that STEP == NBITS and NBITS itself are representable.
    localparam logic [SH_BITS:0] STEP_W  = (SH_BITS + 1)'(STEP);
    localparam logic [SH_BITS:0] NBITS_W = (SH_BITS + 1)'(NBITS);

    generate
        if (NBITS < 2) begin : g_bad_nbits
            $error("seq_shifter: NBITS must be at least 2");
        end
        if (STEP < 1 || STEP > NBITS || (STEP & (STEP - 1)) != 0) begin : g_bad_step
            $error("seq_shifter: STEP must be a power of two no larger than NBITS");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   acc_q, acc_d;
    logic [SH_BITS-1:0] rem_q, rem_d;
    logic [2:0]         mode_q, mode_d;
    logic [NBITS-1:0]   c_q, c_d;
    logic               busy_q, done_q;

    logic [SH_BITS:0]   step_k;
    logic [NBITS-1:0]   shifted;

    function automatic logic is_pass(input logic [2:0] m);
        case (m)
            MODE_SLL, MODE_SRA, MODE_SRL, MODE_ROL, MODE_ROR: return 1'b0;
            default:                                          return 1'b1;
        endcase
    endfunction

    // k is always in 1 .. NBITS-1 when this is used, so the rotate's
    // complementary shift never reaches NBITS.
    function automatic logic [NBITS-1:0] shift_by(input logic [2:0]       m,
                                                  input logic [NBITS-1:0] v,
                                                  input logic [SH_BITS:0] k);
        case (m)
            MODE_SLL: return v << k;
            MODE_SRL: return v >> k;
            // acc keeps the captured sign bit in its MSB across every
            // iteration, so an arithmetic shift of acc replicates it.
            MODE_SRA: return $signed(v) >>> k;
            MODE_ROL: return (v << k) | (v >> (NBITS_W - k));
            MODE_ROR: return (v >> k) | (v << (NBITS_W - k));
            default:  return v;
        endcase
    endfunction

    always_comb begin
        step_k  = ({1'b0, rem_q} > STEP_W) ? STEP_W : {1'b0, rem_q};
        shifted = shift_by(mode_q, acc_q, step_k);
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        c_d     = c_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    acc_d  = y;
                    mode_d = ctrl;
                    rem_d  = amount;
                    if (amount == '0 || is_pass(ctrl)) begin
                        c_d     = y;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = shifted;
                // step_k <= rem_q < NBITS, so its low SH_BITS bits hold it exactly.
                rem_d = rem_q - step_k[SH_BITS-1:0];
                if (rem_d == '0) begin
                    c_d     = shifted;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            c_q     <= c_d;
            // Status flags are flopped from the next state so they are
            // register outputs aligned with the state they describe.
            busy_q  <= (state_d == SHIFT);
            done_q  <= (state_d == DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - self-checking scoreboard bench for seq_shifter (NBITS=16, STEP=4)

module tb_seq_shifter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  ctrl;
    logic [3:0]  amount;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [15:0] c;

    int cyc      = 0;
    int total    = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        logic [15:0] c;
        int          n;
        int          c0;
    } exp_t;

    exp_t sb[$];

    seq_shifter #(.NBITS(16), .STEP(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .ctrl   (ctrl),
        .amount (amount),
        .y      (y),
        .busy   (busy),
        .done   (done),
        .c      (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_pass(input logic [2:0] m);
        return !(m == 3'b010 || m == 3'b001 || m == 3'b011 || m == 3'b100 || m == 3'b101);
    endfunction

    function automatic int n_of(input logic [2:0] m, input int amt);
        if (is_pass(m) || amt == 0) return 0;
        return (amt + 3) / 4;
    endfunction

    // Bit-at-a-time reference model.
    function automatic logic [15:0] model(input logic [2:0] m, input int amt, input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (is_pass(m)) return v;
        for (int i = 0; i < amt; i++) begin
            case (m)
                3'b010:  r = {r[14:0], 1'b0};
                3'b011:  r = {1'b0, r[15:1]};
                3'b001:  r = {r[15], r[15:1]};
                3'b100:  r = {r[14:0], r[15]};
                3'b101:  r = {r[0], r[15:1]};
                default: r = r;
            endcase
        end
        return r;
    endfunction

    // Called at a sample point (#1 after an edge) with an operation in flight.
    task automatic wait_done(input string tag, output int bcnt);
        int   t;
        exp_t e;
        t    = 0;
        bcnt = 0;
        while (done !== 1'b1 && t < 40) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, " done"}, done, 1);
        e = sb.pop_front();
        check({tag, " c"}, c, e.c);
        check({tag, " latency"}, cyc - e.c0, e.n);
        check({tag, " busy at done"}, busy, 0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] m, input int amt,
                          input logic [15:0] v, input logic [15:0] exp_c);
        exp_t e;
        int   b;
        ctrl   = m;
        amount = amt[3:0];
        y      = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.c  = exp_c;
        e.n  = n_of(m, amt);
        e.c0 = cyc;
        sb.push_back(e);
        wait_done(tag, b);
        check({tag, " busy cycles"}, b, e.n);
    endtask

    initial begin
        exp_t e;
        int   b;
        int   dcnt;

        rst_n  = 1'b0;
        start  = 1'b0;
        ctrl   = 3'b000;
        amount = 4'd0;
        y      = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset c", c, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("sll8",  3'b010, 8,  16'h00A5, 16'hA500);
        run_op("sra1",  3'b001, 1,  16'h8004, 16'hC002);
        run_op("srl15", 3'b011, 15, 16'h8000, 16'h0001);
        run_op("rol7",  3'b100, 7,  16'h8001, 16'h00C0);
        run_op("ror4",  3'b101, 4,  16'h1234, 16'h4123);
        run_op("pass",  3'b000, 5,  16'hBEEF, 16'hBEEF);
        run_op("amt0",  3'b010, 0,  16'h1357, 16'h1357);
        run_op("pass7", 3'b111, 9,  16'h2468, 16'h2468);

        // Extra patterns against the bit-serial model.
        run_op("sra15", 3'b001, 15, 16'h8000, model(3'b001, 15, 16'h8000));
        run_op("ror15", 3'b101, 15, 16'h0001, model(3'b101, 15, 16'h0001));
        run_op("sll15", 3'b010, 15, 16'hFFFF, model(3'b010, 15, 16'hFFFF));
        run_op("rol13", 3'b100, 13, 16'hC3A5, model(3'b100, 13, 16'hC3A5));
        run_op("srl3",  3'b011, 3,  16'hF0F0, model(3'b011, 3,  16'hF0F0));

        // Result is held across idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("c held in idle", c, 16'h1E1E);

        // Start during SHIFT is ignored; inputs may change freely.
        ctrl   = 3'b010;
        amount = 4'd12;
        y      = 16'h0001;
        start  = 1'b1;
        @(posedge clk);
        #1;
        e.c  = 16'h1000;
        e.n  = 3;
        e.c0 = cyc;
        sb.push_back(e);
        ctrl   = 3'b101;
        amount = 4'd4;
        y      = 16'hFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hs busy mid", busy, 1);
        wait_done("hs", b);

        // Back-to-back: start held high through DONE.
        ctrl   = 3'b010;
        amount = 4'd4;
        y      = 16'h0003;
        start  = 1'b1;
        @(posedge clk);
        #1;
        e.c  = 16'h0030;
        e.n  = 1;
        e.c0 = cyc;
        sb.push_back(e);
        ctrl   = 3'b001;
        amount = 4'd8;
        y      = 16'h8000;
        wait_done("b2b1", b);
        e.c  = 16'hFF80;
        e.n  = 2;
        e.c0 = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b no idle busy", busy, 1);
        check("b2b done low", done, 0);
        wait_done("b2b2", b);

        // Reset in the second SHIFT cycle of SRL 12.
        ctrl   = 3'b011;
        amount = 4'd12;
        y      = 16'hF000;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset busy", busy, 0);
        check("mid reset done", done, 0);
        check("mid reset c", c, 0);
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcnt++;
        end
        check("no done after abort", dcnt, 0);
        run_op("post reset srl12", 3'b011, 12, 16'hF000, 16'h000F);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Parametrised multi-cycle shifter/rotator for the datapath. It replaces the fixed SLL8/SRA1 combinational shifter with variable shift amounts and five shift modes. The shift runs iteratively, STEP bits per cycle, behind a start/busy/done handshake. It sits between the ALU result bus and the C bus, and the control store sequences it.

## Interface
- NBITS, 32, datapath width; must be ≥ 2.
- SH_BITS, $clog2(NBITS), width of the shift amount.
- STEP, 4, maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ NBITS.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; accepted only when busy = 0.
- ctrl  in  3  mode:
  - 3'b010 SLL
  - 3'b001 SRA
  - 3'b011 SRL
  - 3'b100 ROL
  - 3'b101 ROR
  - any other code is PASS
- amount  in  SH_BITS  shift distance, 0 … NBITS-1.
- y  in  NBITS  signed operand.
- busy  out  1  high while shifting.
- done  out  1  one-cycle pulse; c is valid from this cycle onward.
- c  out  NBITS  signed result register, held until the next result loads.

## Operation
- States: IDLE, SHIFT, DONE.
- Acceptance: start sampled high at edge E0 while in IDLE or DONE.
- Capture at E0: acc ← y, mode ← ctrl, rem ← amount.
  - If rem = 0 or mode = PASS, go to DONE. c ← y is loaded at E0.
  - Otherwise go to SHIFT.
- SHIFT, each edge:
  - k = min(STEP, rem).
  - acc ← acc shifted by k per mode; rem ← rem − k.
  - When the new rem = 0: c ← shifted value and go to DONE.
- Mode rules:
  - SLL and SRL zero-fill.
  - SRA replicates bit NBITS-1 of the captured operand.
  - ROL and ROR wrap bits modulo NBITS.
- Width rules: all shifts are exactly NBITS wide; no carry or overflow output. SH_BITS bounds the amount, so it never reaches NBITS.
- DONE:
  - done = 1 for exactly one cycle.
  - Next state is IDLE, or SHIFT/DONE if start is high (back-to-back acceptance).
- While in SHIFT:
  - start is ignored; no queuing, no effect on the operation in flight.
  - y, ctrl and amount may change freely; only the values captured at E0 are used.
- c changes only on a completion edge (entry to DONE). It is otherwise held, including across IDLE.
- Reset (rst_n low, any time, including mid-shift):
  - state = IDLE; acc, rem, c = 0; busy = 0; done = 0.
  - The operation in progress is abandoned with no done pulse.
- Elaboration: fail with $error if STEP is not a power of two or STEP > NBITS.

## Timing
- n = ceil(amount / STEP), or 0 for PASS or amount = 0.
- Latency:
  - done is high in the cycle following edge E0+n.
  - c is valid from that same cycle.
  - Example: NBITS = 16, STEP = 4, amount = 8 → done in the cycle after E2.
- busy:
  - High in the cycles following E0 … E0+n-1 (SHIFT state).
  - Low in IDLE and DONE.
  - Drops in the same cycle done rises.
- Throughput: one operation every n+1 cycles when start is held high (accepted in each DONE cycle). For n = 0 with start held high, done pulses every cycle.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
All scenarios use NBITS = 16, STEP = 4.
- SLL: y = 0x00A5, amount 8, ctrl 010 → c = 0xA500; done after E2; busy high 2 cycles.
- SRA and SRL:
  - SRA: y = 0x8004, amount 1 → c = 0xC002, done after E1.
  - SRL: y = 0x8000, amount 15 → c = 0x0001, done after E4.
- Rotates:
  - ROL: y = 0x8001, amount 7 → c = 0x00C0.
  - ROR: y = 0x1234, amount 4 → c = 0x4123.
- Zero-length cases:
  - PASS (ctrl 000), amount 5, y = 0xBEEF → c = 0xBEEF; done after E0; busy never high.
  - ctrl 010 with amount 0 gives the same result.
- Handshake:
  - Start SLL 12 on 0x0001; at E1 pulse start with ROR 4 on 0xFFFF and change y → ignored; result c = 0x1000 after E3.
  - Hold start high through DONE with a new request → accepted back-to-back, no idle cycle.
- Reset: assert rst_n low during the second SHIFT cycle of SRL 12 → busy, done, c = 0 immediately; no done pulse; a new start after release completes normally.
